// File: rtl/mem_stage.sv
// Memory pipeline stage: accepts one EX result at a time, performs an aligned
// load/store on a req/gnt/rvalid data bus and hands a single-cycle result to WB.
module mem_stage (
    input  logic        clk,
    input  logic        reset,
    input  logic        ex_valid,
    output logic        ex_ready,
    input  logic [31:0] ex_data,
    input  logic [31:0] ex_store_data,
    input  logic        ex_mem_read,
    input  logic        ex_mem_write,
    input  logic [1:0]  ex_size,
    input  logic        ex_signed,
    input  logic [4:0]  ex_rd,
    input  logic        ex_reg_wen,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [3:0]  dmem_be,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_gnt,
    input  logic        dmem_rvalid,
    input  logic [31:0] dmem_rdata,
    output logic        wb_valid,
    output logic [31:0] wb_data,
    output logic [4:0]  wb_rd,
    output logic        wb_wen,
    output logic        wb_fault
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } state_t;

    state_t      state_r;
    logic [31:0] data_r;
    logic [4:0]  rd_r;
    logic        wen_r;
    logic [1:0]  size_r;
    logic        signed_r;

    // Illegal size, misaligned half/word, or simultaneous read and write.
    function automatic logic is_fault(input logic [1:0] size, input logic [1:0] lo,
                                      input logic rd, input logic wr);
        logic f;
        case (size)
            2'b00:   f = 1'b0;
            2'b01:   f = lo[0];
            2'b10:   f = (lo != 2'b00);
            default: f = 1'b1;
        endcase
        return f | (rd & wr);
    endfunction

    function automatic logic [3:0] calc_be(input logic [1:0] size, input logic [1:0] lo);
        logic [3:0] be;
        case (size)
            2'b00:   be = 4'b0001 << lo;
            2'b01:   be = lo[1] ? 4'b1100 : 4'b0011;
            default: be = 4'b1111;
        endcase
        return be;
    endfunction

    function automatic logic [31:0] calc_wdata(input logic [1:0] size, input logic [31:0] st);
        logic [31:0] w;
        case (size)
            2'b00:   w = {4{st[7:0]}};
            2'b01:   w = {2{st[15:0]}};
            default: w = st;
        endcase
        return w;
    endfunction

    // Move the addressed lane down to bit 0 and extend it to 32 bits.
    function automatic logic [31:0] extract_load(input logic [31:0] rdata, input logic [1:0] size,
                                                 input logic [1:0] lo, input logic sgn);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] res;
        case (lo)
            2'd0:    b = rdata[7:0];
            2'd1:    b = rdata[15:8];
            2'd2:    b = rdata[23:16];
            default: b = rdata[31:24];
        endcase
        h = lo[1] ? rdata[31:16] : rdata[15:0];
        case (size)
            2'b00:   res = {{24{sgn & b[7]}}, b};
            2'b01:   res = {{16{sgn & h[15]}}, h};
            default: res = rdata;
        endcase
        return res;
    endfunction

    assign ex_ready = (state_r == IDLE);

    // Stage FSM with all bus and writeback outputs registered.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r    <= IDLE;
            data_r     <= 32'd0;
            rd_r       <= 5'd0;
            wen_r      <= 1'b0;
            size_r     <= 2'b00;
            signed_r   <= 1'b0;
            dmem_req   <= 1'b0;
            dmem_we    <= 1'b0;
            dmem_addr  <= 32'd0;
            dmem_be    <= 4'd0;
            dmem_wdata <= 32'd0;
            wb_valid   <= 1'b0;
            wb_data    <= 32'd0;
            wb_rd      <= 5'd0;
            wb_wen     <= 1'b0;
            wb_fault   <= 1'b0;
        end else begin
            wb_valid <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (ex_valid) begin
                        data_r   <= ex_data;
                        rd_r     <= ex_rd;
                        wen_r    <= ex_reg_wen;
                        size_r   <= ex_size;
                        signed_r <= ex_signed;
                        if (!ex_mem_read && !ex_mem_write) begin
                            wb_valid <= 1'b1;
                            wb_data  <= ex_data;
                            wb_rd    <= ex_rd;
                            wb_wen   <= ex_reg_wen;
                            wb_fault <= 1'b0;
                        end else if (is_fault(ex_size, ex_data[1:0], ex_mem_read, ex_mem_write)) begin
                            wb_valid <= 1'b1;
                            wb_data  <= ex_data;
                            wb_rd    <= ex_rd;
                            wb_wen   <= 1'b0;
                            wb_fault <= 1'b1;
                        end else begin
                            state_r    <= REQ;
                            dmem_req   <= 1'b1;
                            dmem_we    <= ex_mem_write;
                            dmem_addr  <= {ex_data[31:2], 2'b00};
                            dmem_be    <= calc_be(ex_size, ex_data[1:0]);
                            dmem_wdata <= calc_wdata(ex_size, ex_store_data);
                        end
                    end else begin
                        state_r <= IDLE;
                    end
                end
                REQ: begin
                    // Bus outputs stay frozen until the grant; rvalid is not looked at here.
                    if (dmem_gnt) begin
                        dmem_req <= 1'b0;
                        if (dmem_we) begin
                            state_r  <= IDLE;
                            wb_valid <= 1'b1;
                            wb_data  <= data_r;
                            wb_rd    <= rd_r;
                            wb_wen   <= 1'b0;
                            wb_fault <= 1'b0;
                        end else begin
                            state_r <= WAIT;
                        end
                    end else begin
                        state_r <= REQ;
                    end
                end
                WAIT: begin
                    if (dmem_rvalid) begin
                        state_r  <= IDLE;
                        wb_valid <= 1'b1;
                        wb_data  <= extract_load(dmem_rdata, size_r, data_r[1:0], signed_r);
                        wb_rd    <= rd_r;
                        wb_wen   <= wen_r;
                        wb_fault <= 1'b0;
                    end else begin
                        state_r <= WAIT;
                    end
                end
                default: begin
                    state_r  <= IDLE;
                    dmem_req <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Randomized self-checking bench for mem_stage; expected results come from
// arithmetic on the access rules, one transaction at a time.
module tb_mem_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        ex_valid;
    logic        ex_ready;
    logic [31:0] ex_data;
    logic [31:0] ex_store_data;
    logic        ex_mem_read;
    logic        ex_mem_write;
    logic [1:0]  ex_size;
    logic        ex_signed;
    logic [4:0]  ex_rd;
    logic        ex_reg_wen;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_wdata;
    logic        dmem_gnt;
    logic        dmem_rvalid;
    logic [31:0] dmem_rdata;
    logic        wb_valid;
    logic [31:0] wb_data;
    logic [4:0]  wb_rd;
    logic        wb_wen;
    logic        wb_fault;

    int n_checks = 0;
    int n_errors = 0;

    mem_stage dut (
        .clk(clk), .reset(reset), .ex_valid(ex_valid), .ex_ready(ex_ready),
        .ex_data(ex_data), .ex_store_data(ex_store_data), .ex_mem_read(ex_mem_read),
        .ex_mem_write(ex_mem_write), .ex_size(ex_size), .ex_signed(ex_signed),
        .ex_rd(ex_rd), .ex_reg_wen(ex_reg_wen), .dmem_req(dmem_req), .dmem_we(dmem_we),
        .dmem_addr(dmem_addr), .dmem_be(dmem_be), .dmem_wdata(dmem_wdata),
        .dmem_gnt(dmem_gnt), .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata),
        .wb_valid(wb_valid), .wb_data(wb_data), .wb_rd(wb_rd), .wb_wen(wb_wen),
        .wb_fault(wb_fault)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    task automatic scramble_ex();
        ex_data       = $urandom;
        ex_store_data = $urandom;
        ex_mem_read   = 1'($urandom_range(0, 1));
        ex_mem_write  = 1'($urandom_range(0, 1));
        ex_size       = 2'($urandom_range(0, 3));
        ex_signed     = 1'($urandom_range(0, 1));
        ex_rd         = 5'($urandom_range(0, 31));
        ex_reg_wen    = 1'($urandom_range(0, 1));
    endtask

    task automatic check_reset_state();
        chk("rst_ex_ready", 32'(ex_ready), 32'd1);
        chk("rst_req", 32'(dmem_req), 32'd0);
        chk("rst_we", 32'(dmem_we), 32'd0);
        chk("rst_addr", dmem_addr, 32'd0);
        chk("rst_be", 32'(dmem_be), 32'd0);
        chk("rst_wdata", dmem_wdata, 32'd0);
        chk("rst_wb_valid", 32'(wb_valid), 32'd0);
        chk("rst_wb_data", wb_data, 32'd0);
        chk("rst_wb_rd", 32'(wb_rd), 32'd0);
        chk("rst_wb_wen", 32'(wb_wen), 32'd0);
        chk("rst_wb_fault", 32'(wb_fault), 32'd0);
    endtask

    // One complete transaction: accept, optional bus handshake, WB pulse, idle cycle.
    // rst_at: 0 none, 1 reset in REQ, 2 reset in WAIT (access is abandoned).
    task automatic do_op(input bit mr, input bit mw, input logic [1:0] sz, input bit sg,
                         input logic [31:0] addr, input logic [31:0] st, input logic [4:0] rd,
                         input bit wen, input int stall, input int rlat,
                         input logic [31:0] rdat, input int rst_at);
        bit          flt;
        int          lo;
        logic [31:0] exp_be, exp_wd, exp_ld, lane;
        logic        exp_wen;
        lo  = int'(addr[1:0]);
        flt = (sz == 2'd3) || (sz == 2'd1 && (lo % 2) != 0) || (sz == 2'd2 && lo != 0) || (mr && mw);
        @(negedge clk);
        chk("ready_before_accept", 32'(ex_ready), 32'd1);
        ex_valid = 1'b1; ex_data = addr; ex_store_data = st; ex_mem_read = mr;
        ex_mem_write = mw; ex_size = sz; ex_signed = sg; ex_rd = rd; ex_reg_wen = wen;
        @(negedge clk);
        ex_valid = 1'b0;
        scramble_ex();
        if (!mr && !mw) begin
            chk("alu_valid", 32'(wb_valid), 32'd1);
            chk("alu_data", wb_data, addr);
            chk("alu_rd", 32'(wb_rd), 32'(rd));
            chk("alu_wen", 32'(wb_wen), 32'(wen));
            chk("alu_fault", 32'(wb_fault), 32'd0);
            chk("alu_no_req", 32'(dmem_req), 32'd0);
            exp_wen = wen;
        end else if (flt) begin
            chk("flt_valid", 32'(wb_valid), 32'd1);
            chk("flt_fault", 32'(wb_fault), 32'd1);
            chk("flt_wen", 32'(wb_wen), 32'd0);
            chk("flt_data", wb_data, addr);
            chk("flt_no_req", 32'(dmem_req), 32'd0);
            chk("flt_ready", 32'(ex_ready), 32'd1);
            exp_wen = 1'b0;
        end else begin
            exp_be = (sz == 2'd0) ? (32'd1 << lo) : (sz == 2'd1) ? (32'd3 << (2 * (lo / 2))) : 32'd15;
            exp_wd = (sz == 2'd0) ? (32'(st[7:0]) * 32'h01010101) :
                     (sz == 2'd1) ? (32'(st[15:0]) * 32'h00010001) : st;
            for (int i = 0; i <= stall; i++) begin
                if (i > 0) @(negedge clk);
                chk("req_active", 32'(dmem_req), 32'd1);
                chk("req_we", 32'(dmem_we), 32'(mw));
                chk("req_addr", dmem_addr, addr - 32'(lo));
                chk("req_be", 32'(dmem_be), exp_be);
                chk("req_wdata", dmem_wdata, exp_wd);
                chk("req_ready", 32'(ex_ready), 32'd0);
                chk("req_no_wb", 32'(wb_valid), 32'd0);
                if (rst_at == 1 && i == stall) begin
                    reset = 1'b1;
                    @(negedge clk);
                    reset = 1'b0;
                    check_reset_state();
                    return;
                end
                dmem_gnt    = (i == stall);
                dmem_rvalid = (i == stall) ? 1'b1 : 1'($urandom_range(0, 1));
                dmem_rdata  = ~rdat;
            end
            @(negedge clk);
            dmem_gnt = 1'b0; dmem_rvalid = 1'b0;
            chk("post_gnt_no_req", 32'(dmem_req), 32'd0);
            if (mw) begin
                chk("st_valid", 32'(wb_valid), 32'd1);
                chk("st_wen", 32'(wb_wen), 32'd0);
                chk("st_fault", 32'(wb_fault), 32'd0);
                chk("st_ready", 32'(ex_ready), 32'd1);
                exp_wen = 1'b0;
            end else begin
                chk("ld_wait_no_wb", 32'(wb_valid), 32'd0);
                chk("ld_wait_ready", 32'(ex_ready), 32'd0);
                for (int j = 0; j < rlat; j++) begin
                    @(negedge clk);
                    chk("ld_wait_hold", 32'(wb_valid), 32'd0);
                end
                if (rst_at == 2) begin
                    reset = 1'b1;
                    @(negedge clk);
                    reset = 1'b0;
                    check_reset_state();
                    dmem_rvalid = 1'b1; dmem_rdata = rdat;
                    @(negedge clk);
                    dmem_rvalid = 1'b0;
                    chk("abandon_no_wb", 32'(wb_valid), 32'd0);
                    chk("abandon_ready", 32'(ex_ready), 32'd1);
                    chk("abandon_no_req", 32'(dmem_req), 32'd0);
                    return;
                end
                dmem_rvalid = 1'b1; dmem_rdata = rdat;
                @(negedge clk);
                dmem_rvalid = 1'b0;
                if (sz == 2'd2) begin
                    exp_ld = rdat;
                end else begin
                    lane   = (sz == 2'd0) ? ((rdat >> (8 * lo)) % 32'h100) : ((rdat >> (16 * (lo / 2))) % 32'h10000);
                    exp_ld = lane;
                    if (sg && sz == 2'd0 && lane >= 32'h80) exp_ld = lane - 32'h100;
                    if (sg && sz == 2'd1 && lane >= 32'h8000) exp_ld = lane - 32'h10000;
                end
                chk("ld_valid", 32'(wb_valid), 32'd1);
                chk("ld_data", wb_data, exp_ld);
                chk("ld_rd", 32'(wb_rd), 32'(rd));
                chk("ld_wen", 32'(wb_wen), 32'(wen));
                chk("ld_fault", 32'(wb_fault), 32'd0);
                chk("ld_ready", 32'(ex_ready), 32'd1);
                exp_wen = wen;
            end
        end
        // Pulse is one cycle wide; stray rvalid while idle must be ignored.
        dmem_rvalid = 1'b1; dmem_rdata = $urandom;
        @(negedge clk);
        dmem_rvalid = 1'b0;
        chk("wb_pulse_end", 32'(wb_valid), 32'd0);
        chk("wb_wen_hold", 32'(wb_wen), 32'(exp_wen));
        chk("idle_no_req", 32'(dmem_req), 32'd0);
    endtask

    initial begin
        reset = 1'b1; ex_valid = 1'b0; dmem_gnt = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = 32'd0;
        scramble_ex();
        repeat (2) @(negedge clk);
        reset = 1'b0;
        check_reset_state();

        do_op(1'b0, 1'b0, 2'd2, 1'b0, 32'h12345678, 32'd0, 5'd3, 1'b1, 0, 0, 32'd0, 0);
        do_op(1'b1, 1'b0, 2'd0, 1'b1, 32'h00000103, 32'd0, 5'd7, 1'b1, 2, 0, 32'h80AABBCC, 0);
        do_op(1'b0, 1'b1, 2'd1, 1'b0, 32'h00000202, 32'h0000BEEF, 5'd4, 1'b1, 1, 0, 32'd0, 0);
        do_op(1'b1, 1'b0, 2'd2, 1'b0, 32'h00000101, 32'd0, 5'd5, 1'b1, 0, 0, 32'd0, 0);
        do_op(1'b1, 1'b0, 2'd1, 1'b0, 32'h00000302, 32'd0, 5'd9, 1'b1, 0, 3, 32'h8001F00D, 0);
        do_op(1'b1, 1'b0, 2'd3, 1'b0, 32'h00000400, 32'd0, 5'd1, 1'b1, 0, 0, 32'd0, 0);
        do_op(1'b1, 1'b1, 2'd0, 1'b0, 32'h00000400, 32'd0, 5'd1, 1'b1, 0, 0, 32'd0, 0);
        do_op(1'b1, 1'b0, 2'd2, 1'b0, 32'h00000500, 32'd0, 5'd2, 1'b1, 1, 1, 32'hCAFEF00D, 2);
        do_op(1'b0, 1'b1, 2'd2, 1'b0, 32'h00000600, 32'h11223344, 5'd2, 1'b0, 2, 0, 32'd0, 1);

        // Reset wins over a simultaneous accept.
        @(negedge clk);
        reset = 1'b1; ex_valid = 1'b1; ex_mem_read = 1'b0; ex_mem_write = 1'b0;
        @(negedge clk);
        reset = 1'b0; ex_valid = 1'b0;
        check_reset_state();

        for (int k = 0; k < 60; k++) begin
            do_op(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                  1'($urandom_range(0, 1)), $urandom, $urandom, 5'($urandom_range(0, 31)),
                  1'($urandom_range(0, 1)), $urandom_range(0, 3), $urandom_range(0, 3), $urandom, 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 SHALL have one clock and a synchronous, active-high reset.
REQ-002 SHALL have these ports (name  direction  width  meaning):
- clk  in  1  single clock; all state changes on its rising edge
- reset  in  1  synchronous, active-high reset
- ex_valid  in  1  EX result present this cycle
- ex_ready  out  1  stage can accept an EX result
- ex_data  in  32  EX data_out; the address for loads and stores
- ex_store_data  in  32  store operand (srcB path)
- ex_mem_read  in  1  load operation
- ex_mem_write  in  1  store operation
- ex_size  in  2  00 byte, 01 halfword, 10 word, 11 illegal
- ex_signed  in  1  sign-extend a byte/half load
- ex_rd  in  5  destination register
- ex_reg_wen  in  1  destination write enable
- dmem_req  out  1  memory request
- dmem_we  out  1  1 = store
- dmem_addr  out  32  word address {addr[31:2],2'b00}
- dmem_be  out  4  byte enables
- dmem_wdata  out  32  lane-replicated store data
- dmem_gnt  in  1  request accepted this cycle
- dmem_rvalid  in  1  load data valid
- dmem_rdata  in  32  load data, little-endian lanes
- wb_valid  out  1  one-cycle result pulse to WB
- wb_data  out  32  result data
- wb_rd  out  5  destination register
- wb_wen  out  1  register write enable
- wb_fault  out  1  misaligned or illegal access

Function
REQ-003 SHALL implement an FSM with states IDLE, REQ and WAIT; ex_ready SHALL be 1 only in IDLE.
REQ-004 Accept SHALL occur when ex_valid and ex_ready are both 1; at accept the stage SHALL capture all ex_* inputs.
REQ-005 Non-memory op (neither read nor write) accepted in cycle N: wb_valid=1 in N+1 with wb_data=ex_data, wb_rd=ex_rd, wb_wen=ex_reg_wen, wb_fault=0; state stays IDLE.
REQ-006 Fault condition: size=11; or half with addr[0]=1; or word with addr[1:0]!=00; or read and write both set.
REQ-007 A faulting memory op accepted in cycle N SHALL give wb_valid=1 and wb_fault=1 in N+1, with wb_wen=0 and wb_data=ex_data; no dmem_req SHALL be issued.
REQ-008 A legal memory op accepted in cycle N SHALL move the FSM to REQ, with dmem_req=1 from N+1.
REQ-009 In REQ, dmem_req and all dmem_* outputs SHALL be held stable until the cycle in which dmem_gnt=1.
REQ-010 Store, gnt in cycle G: wb_valid=1 in G+1 with wb_wen=0 and wb_fault=0, and FSM to IDLE in G+1.
REQ-011 Load, gnt in cycle G: FSM to WAIT in G+1.
REQ-012 In WAIT, dmem_rvalid in cycle R SHALL give wb_valid=1 in R+1 with the extracted data, wb_wen=captured reg_wen, and FSM to IDLE.
REQ-013 dmem_rvalid SHALL be ignored outside WAIT; dmem_rvalid in the gnt cycle itself SHALL be ignored (earliest rvalid is G+1).
REQ-014 Byte enables: byte SHALL use be=0001<<addr[1:0] with wdata={4{store[7:0]}}; half SHALL use be=0011<<{addr[1],1'b0} with wdata={2{store[15:0]}}; word SHALL use be=1111 with wdata=store.
REQ-015 Load extraction: the selected byte or half SHALL be shifted to bit 0, then sign- or zero-extended per ex_signed; a word load SHALL pass unchanged.
REQ-016 wb_valid SHALL be a single-cycle pulse; wb_data, wb_rd, wb_wen and wb_fault SHALL hold their last values when wb_valid=0.
REQ-017 dmem_req SHALL be 0 in IDLE and WAIT.

Reset
REQ-018 When reset=1 at a clock edge, the stage SHALL enter IDLE and set dmem_req=0, dmem_we=0, dmem_addr=0, dmem_be=0, dmem_wdata=0, wb_valid=0, wb_data=0, wb_rd=0, wb_wen=0, wb_fault=0; ex_ready=1 after that edge.
REQ-019 Reset in REQ or WAIT SHALL abandon the access; a later dmem_rvalid SHALL produce no wb_valid.
REQ-020 Reset SHALL take priority over accept in the same cycle.

Verification
REQ-021 Non-memory op: ex_data=0x12345678, rd=3, wen=1 -> wb_valid in the next cycle, wb_data=0x12345678, wb_rd=3, wb_wen=1.
REQ-022 Signed byte load at addr 0x103 with rdata=0x80AABBCC, gnt after 2 cycles of stall, rvalid 1 cycle later -> ex_ready=0 throughout, wb_data=0xFFFFFF80.
REQ-023 Half store at 0x202 with store=0x0000BEEF -> dmem_be=1100, dmem_wdata=0xBEEFBEEF, dmem_addr=0x200; wb_wen=0 after gnt.
REQ-024 Word load at 0x101 -> no dmem_req, wb_fault=1, wb_wen=0 in the next cycle.
REQ-025 Reset asserted in WAIT, then rvalid=1 -> no wb_valid, FSM in IDLE, ex_ready=1.
